// File: rtl/hamming_pkg.sv
// Shared Hamming code helpers: codeword layout and parity-width check.
// Used by both the encoder and the decode pipeline.
package hamming_pkg;

  localparam int N_DEFAULT  = 7;
  localparam int R_DEFAULT  = 4;
  localparam int CW_DEFAULT = 16;

  // Parity bits occupy the power-of-two positions of the 1-based codeword.
  function automatic bit is_parity_pos(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  // Codeword position of data bit j (1-based).
  function automatic int data_pos(input int j);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 256; p++) begin
      if (pos == 0 && !is_parity_pos(p)) begin
        cnt++;
        if (cnt == j) pos = p;
      end
    end
    return pos;
  endfunction

  // Smallest R with 2**R >= n+R+1.
  function automatic int min_parity_bits(input int n);
    int res;
    res = 0;
    for (int r = 1; r < 31; r++) begin
      if (res == 0 && (1 << r) >= n + r + 1) res = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome: XOR of the indices of every set codeword bit.
module hamming_syndrome #(
  parameter int N = 7,
  parameter int R = 4
) (
  input  logic [1:N+R]  code,
  output logic [R-1:0]  syndrome
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i <= N + R; i++) begin
      if (code[i]) syndrome = syndrome ^ R'(i);
    end
  end

endmodule

// File: rtl/hamming_decode_pipe.sv
// Two-stage Hamming decoder with valid/ready flow control and saturating
// corrected/uncorrectable word counters.
module hamming_decode_pipe
  import hamming_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int R  = R_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:N+R]   in_code,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:N]     out_data,
  output logic [R-1:0]   out_syndrome,
  output logic           out_corrected,
  output logic           out_uncorrectable,
  input  logic           cnt_clear,
  output logic [CW-1:0]  cnt_corrected,
  output logic [CW-1:0]  cnt_uncorr
);

  if (R < min_parity_bits(N)) begin : g_bad_params
    $error("hamming_decode_pipe: R too small for N data bits");
  end

  localparam logic [R-1:0] MAX_POS = R'(N + R);

  logic           s1_valid;
  logic [1:N+R]   s1_code;
  logic [R-1:0]   s1_syn;
  logic [R-1:0]   in_syn;
  logic           adv1;
  logic           adv2;
  logic           out_hs;
  logic [1:N+R]   fixed;
  logic [1:N]     dec_data;
  logic           dec_corr;
  logic           dec_uncorr;

  hamming_syndrome #(.N(N), .R(R)) u_syndrome (
    .code     (in_code),
    .syndrome (in_syn)
  );

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_hs   = out_valid && out_ready;

  // Syndromes past the last position have no bit to flip; data passes through raw.
  always_comb begin
    fixed = s1_code;
    for (int i = 1; i <= N + R; i++) begin
      if (s1_syn == R'(i)) fixed[i] = ~s1_code[i];
    end
    for (int j = 1; j <= N; j++) begin
      dec_data[j] = fixed[data_pos(j)];
    end
    dec_corr   = (s1_syn != '0) && (s1_syn <= MAX_POS);
    dec_uncorr = (s1_syn > MAX_POS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data          <= dec_data;
        out_syndrome      <= s1_syn;
        out_corrected     <= dec_corr;
        out_uncorrectable <= dec_uncorr;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else if (out_hs) begin
      if (out_corrected && cnt_corrected != '1) cnt_corrected <= cnt_corrected + 1'b1;
      if (out_uncorrectable && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decode_pipe.sv
// Self-checking bench for hamming_decode_pipe: directed vectors, backpressure,
// saturation/clear, random traffic against a reference decoder, reset mid-flight.
module tb_hamming_decode_pipe;

  localparam int N = 7;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [10:0] in_code = '0;

  logic        in_ready, out_valid, out_corrected, out_uncorrectable;
  logic [6:0]  out_data;
  logic [3:0]  out_syndrome;
  logic [15:0] cnt_corrected, cnt_uncorr;

  logic        s_in_ready, s_out_valid, s_out_corrected, s_out_uncorrectable;
  logic [6:0]  s_out_data;
  logic [3:0]  s_out_syndrome;
  logic [1:0]  s_cnt_corrected, s_cnt_uncorr;

  hamming_decode_pipe #(.N(N), .R(R), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable), .cnt_clear(cnt_clear),
    .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  hamming_decode_pipe #(.N(N), .R(R), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_syndrome(s_out_syndrome), .out_corrected(s_out_corrected),
    .out_uncorrectable(s_out_uncorrectable), .cnt_clear(cnt_clear),
    .cnt_corrected(s_cnt_corrected), .cnt_uncorr(s_cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  typedef struct {
    logic [10:0] code;
    logic [6:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        unc;
    int          cc;
    int          cu;
  } dir_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   m_cc = 0, m_cu = 0, s_cc = 0, s_cu = 0;
  bit   prev_stall = 0;
  exp_t held;
  int   cyc = 0;
  bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit isPow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Reference decoder straight from the code definition; position p is bit 11-p.
  function automatic exp_t refDecode(input logic [10:0] code);
    exp_t        e;
    int          syn;
    int          d;
    logic [10:0] w;
    syn = 0;
    d   = 0;
    w   = code;
    for (int p = 1; p <= 11; p++) if (code[11-p]) syn ^= p;
    e.syn  = syn[3:0];
    e.corr = (syn >= 1) && (syn <= 11);
    e.unc  = (syn > 11);
    if (e.corr) w[11-syn] = ~w[11-syn];
    for (int p = 1; p <= 11; p++) if (!isPow2(p)) d = d * 2 + int'(w[11-p]);
    e.data = d[6:0];
    return e;
  endfunction

  function automatic logic [10:0] encode(input logic [6:0] data);
    logic [10:0] w;
    int          k;
    int          syn;
    w   = '0;
    k   = 6;
    syn = 0;
    for (int p = 1; p <= 11; p++) begin
      if (!isPow2(p)) begin
        w[11-p] = data[k];
        k--;
      end
    end
    for (int p = 1; p <= 11; p++) if (w[11-p]) syn ^= p;
    for (int b = 0; b < 4; b++) w[11-(1<<b)] = syn[b];
    return w;
  endfunction

  function automatic logic [10:0] flipPos(input logic [10:0] w, input int p);
    logic [10:0] r;
    r = w;
    r[11-p] = ~r[11-p];
    return r;
  endfunction

  function automatic logic [10:0] randomWord();
    logic [10:0] w;
    int          nerr;
    int          p1;
    int          p2;
    w    = encode(7'($urandom_range(0, 127)));
    nerr = $urandom_range(0, 2);
    p1   = $urandom_range(1, 11);
    p2   = (p1 % 11) + 1;
    if (nerr >= 1) w = flipPos(w, p1);
    if (nerr == 2) w = flipPos(w, p2);
    return w;
  endfunction

  // Scoreboard and counter model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    exp_ready = !(sb.size() == 2 && !out_ready);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("sat_in_ready", s_in_ready, exp_ready);
    if (sb.size() == 0) checkOutput("no_stale_valid", out_valid, 1'b0);
    if (prev_stall) begin
      checkOutput("stall_valid", out_valid, 1'b1);
      checkOutput("stall_data", out_data, held.data);
      checkOutput("stall_syn", out_syndrome, held.syn);
      checkOutput("stall_corr", out_corrected, held.corr);
      checkOutput("stall_unc", out_uncorrectable, held.unc);
    end
    checkOutput("cnt_corrected", cnt_corrected, m_cc);
    checkOutput("cnt_uncorr", cnt_uncorr, m_cu);
    checkOutput("sat_cnt_corrected", s_cnt_corrected, s_cc);
    checkOutput("sat_cnt_uncorr", s_cnt_uncorr, s_cu);
    if (rst) begin
      sb.delete();
      m_cc = 0; m_cu = 0; s_cc = 0; s_cu = 0;
      prev_stall = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_word", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_syndrome", out_syndrome, e.syn);
          checkOutput("out_corrected", out_corrected, e.corr);
          checkOutput("out_uncorrectable", out_uncorrectable, e.unc);
          checkOutput("sat_out_data", s_out_data, e.data);
          checkOutput("sat_out_syndrome", s_out_syndrome, e.syn);
          checkOutput("sat_out_flags", {s_out_corrected, s_out_uncorrectable}, {e.corr, e.unc});
          if (e.corr) begin
            if (m_cc < 65535) m_cc++;
            if (s_cc < 3) s_cc++;
          end
          if (e.unc) begin
            if (m_cu < 65535) m_cu++;
            if (s_cu < 3) s_cu++;
          end
        end
      end
      if (cnt_clear) begin
        m_cc = 0; m_cu = 0; s_cc = 0; s_cu = 0;
      end
      if (in_valid && in_ready) sb.push_back(refDecode(in_code));
      prev_stall     = out_valid && !out_ready;
      held.data = out_data;
      held.syn  = out_syndrome;
      held.corr = out_corrected;
      held.unc  = out_uncorrectable;
    end
  end

  // Offers one word and returns right after the edge that accepts it.
  task automatic applyStimulus(input logic [10:0] code, input bit bp);
    bit acc;
    int tries;
    in_valid = 1'b1;
    in_code  = code;
    tries    = 0;
    acc      = 1'b0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = pat[cyc % 4];
        cyc++;
      end
      tries++;
    end
    if (!acc) checkOutput("accept_timeout", acc, 1'b1);
  endtask

  task automatic drainPipe(input bit bp);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = pat[cyc % 4];
        cyc++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    dir_t        dirs[4];
    logic [10:0] w;
    bit          acc;
    int          bp_data[6] = '{12, 5, 37, 43, 72, 14};
    int          sat_data[5] = '{3, 9, 50, 100, 127};
    int          sat_pos[5] = '{1, 3, 6, 10, 11};

    dirs[0] = '{code: 11'h29C, data: 7'd12, syn: 4'd0,  corr: 1'b0, unc: 1'b0, cc: 0, cu: 0};
    dirs[1] = '{code: 11'h2DC, data: 7'd12, syn: 4'd5,  corr: 1'b1, unc: 1'b0, cc: 1, cu: 0};
    dirs[2] = '{code: 11'h294, data: 7'd12, syn: 4'd8,  corr: 1'b1, unc: 1'b0, cc: 2, cu: 0};
    dirs[3] = '{code: 11'h214, data: 7'd12, syn: 4'd12, corr: 1'b0, unc: 1'b1, cc: 2, cu: 1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_data", out_data, 7'd0);
    checkOutput("reset_cnt", {cnt_corrected, cnt_uncorr}, 32'd0);

    // Directed vectors with an idle pipeline: exact two-cycle latency.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_code   = dirs[i].code;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("latency_not_early", out_valid, 1'b0);
      @(negedge clk);
      checkOutput("latency_valid", out_valid, 1'b1);
      checkOutput("dir_data", out_data, dirs[i].data);
      checkOutput("dir_syndrome", out_syndrome, dirs[i].syn);
      checkOutput("dir_corrected", out_corrected, dirs[i].corr);
      checkOutput("dir_uncorrectable", out_uncorrectable, dirs[i].unc);
      @(negedge clk);
      checkOutput("dir_cnt_corrected", cnt_corrected, dirs[i].cc);
      checkOutput("dir_cnt_uncorr", cnt_uncorr, dirs[i].cu);
      checkOutput("dir_sat_cnt_corrected", s_cnt_corrected, dirs[i].cc);
    end

    // Back-to-back stream under a 1-0-0-1 out_ready pattern.
    cyc = 0;
    for (int i = 0; i < 6; i++) applyStimulus(encode(7'(bp_data[i])), 1'b1);
    in_valid = 1'b0;
    drainPipe(1'b1);

    // Five more corrected words push the 2-bit counter past its ceiling.
    for (int i = 0; i < 5; i++) applyStimulus(flipPos(encode(7'(sat_data[i])), sat_pos[i]), 1'b0);
    in_valid = 1'b0;
    drainPipe(1'b0);
    @(negedge clk);
    checkOutput("sat_sticks_at_3", s_cnt_corrected, 2'd3);
    checkOutput("main_cnt_7", cnt_corrected, 16'd7);

    // Clear coinciding with a corrected handshake wins.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_code  = flipPos(encode(7'd20), 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cnt_clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_handshake_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    checkOutput("clear_wins_main", cnt_corrected, 16'd0);
    checkOutput("clear_wins_sat", s_cnt_corrected, 2'd0);

    // Random traffic with random gaps, backpressure and clears.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = randomWord();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clear = ($urandom_range(0, 31) == 0);
    end
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
    drainPipe(1'b0);

    // Fill both stages, stall, then reset with words in flight.
    out_ready = 1'b0;
    applyStimulus(encode(7'd1), 1'b0);
    applyStimulus(encode(7'd2), 1'b0);
    in_code = encode(7'd3);
    @(negedge clk);
    checkOutput("full_stall_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    checkOutput("midreset_cnt", {cnt_corrected, cnt_uncorr}, 32'd0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midreset_no_stale", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
